// File: rtl/beamformer_pkg.sv
// ============================================================================
// Module : beamformer_pkg
// Brief  : Shared beamformer constants, width helpers and sequencer states.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package beamformer_pkg;

  localparam int NUMBER_OF_BITS = 8;
  localparam int BUFFER_SIZE    = 16;
  localparam int NUM_CHANNELS   = 2;

  // Channel select stays at least one bit wide even for a single channel.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CH_W  = ch_width(NUM_CHANNELS);
  localparam int IDX_W = $clog2(BUFFER_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_OUTPUT = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/beam_delay_regfile.sv
// ============================================================================
// Module : beam_delay_regfile
// Brief  : Host-written shadow delays, frame-synchronous active copy, clamping.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module beam_delay_regfile #(
  parameter  int NUM_CHANNELS = beamformer_pkg::NUM_CHANNELS,
  parameter  int BUFFER_SIZE  = beamformer_pkg::BUFFER_SIZE,
  localparam int CH_W         = beamformer_pkg::ch_width(NUM_CHANNELS),
  localparam int IDX_W        = $clog2(BUFFER_SIZE)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                i_cfg_we,
  input  logic [CH_W-1:0]                     i_cfg_chan,
  input  logic [IDX_W-1:0]                    i_cfg_delay,
  input  logic                                i_cfg_commit,
  input  logic                                i_frame_accept,
  output logic [NUM_CHANNELS-1:0][IDX_W-1:0]  o_active_nxt,
  output logic                                o_cfg_err
);
  import beamformer_pkg::*;

  logic [NUM_CHANNELS-1:0][IDX_W-1:0] r_shadow;
  logic [NUM_CHANNELS-1:0][IDX_W-1:0] r_active;
  logic [NUM_CHANNELS-1:0][IDX_W-1:0] w_shadow_nxt;
  logic [NUM_CHANNELS-1:0][IDX_W-1:0] w_active_nxt;
  logic                               r_commit_pending;
  logic                               r_cfg_err;
  logic                               w_chan_ok;
  logic                               w_clamp;
  logic [IDX_W-1:0]                   w_delay;

  always_comb begin
    w_chan_ok = int'(i_cfg_chan) < NUM_CHANNELS;
    w_clamp   = int'(i_cfg_delay) > (BUFFER_SIZE - 1);
    w_delay   = w_clamp ? IDX_W'(BUFFER_SIZE - 1) : i_cfg_delay;
    w_shadow_nxt = r_shadow;
    if (i_cfg_we && w_chan_ok)
      w_shadow_nxt[i_cfg_chan] = w_delay;
    // A same-cycle write and commit on an accepted frame both reach that frame.
    w_active_nxt = (i_frame_accept && (r_commit_pending || i_cfg_commit)) ?
                   w_shadow_nxt : r_active;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow         <= '0;
      r_active         <= '0;
      r_commit_pending <= 1'b0;
      r_cfg_err        <= 1'b0;
    end else begin
      r_shadow         <= w_shadow_nxt;
      r_active         <= w_active_nxt;
      r_commit_pending <= i_frame_accept ? 1'b0 : (r_commit_pending | i_cfg_commit);
      r_cfg_err        <= i_cfg_we && (!w_chan_ok || w_clamp);
    end
  end

  assign o_active_nxt = w_active_nxt;
  assign o_cfg_err    = r_cfg_err;

endmodule

`default_nettype wire

// File: rtl/beam_delay_sequencer.sv
// ============================================================================
// Module : beam_delay_sequencer
// Brief  : Delay-and-sum frame sequencer; BEAM_SAT_EN selects saturating output.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module beam_delay_sequencer #(
  parameter  int NUM_CHANNELS   = beamformer_pkg::NUM_CHANNELS,
  parameter  int NUMBER_OF_BITS = beamformer_pkg::NUMBER_OF_BITS,
  parameter  int BUFFER_SIZE    = beamformer_pkg::BUFFER_SIZE,
  parameter  int OUT_SHIFT      = 1,
  localparam int CH_W           = beamformer_pkg::ch_width(NUM_CHANNELS),
  localparam int IDX_W          = $clog2(BUFFER_SIZE),
  localparam int ACC_W          = NUMBER_OF_BITS + CH_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_frame_strobe,
  input  logic                             i_cfg_we,
  input  logic [CH_W-1:0]                  i_cfg_chan,
  input  logic [IDX_W-1:0]                 i_cfg_delay,
  input  logic                             i_cfg_commit,
  output logic                             o_rd_en,
  output logic [CH_W-1:0]                  o_rd_chan,
  output logic [IDX_W-1:0]                 o_rd_index,
  input  logic signed [NUMBER_OF_BITS-1:0] i_rd_data,
  output logic                             o_out_valid,
  input  logic                             i_out_ready,
  output logic signed [NUMBER_OF_BITS-1:0] o_out_data,
  output logic                             o_busy,
  output logic                             o_overrun,
  output logic                             o_cfg_err
);
  import beamformer_pkg::*;

  localparam logic [CH_W-1:0] c_last_chan = CH_W'(NUM_CHANNELS - 1);

  state_t                             r_state;
  logic signed [ACC_W-1:0]            r_acc;
  logic signed [ACC_W-1:0]            w_sum;
  logic [NUMBER_OF_BITS-1:0]          w_result;
  logic [NUM_CHANNELS-1:0][IDX_W-1:0] w_active_nxt;
  logic [CH_W-1:0]                    w_next_chan;
  logic                               w_frame_accept;
  logic                               r_rd_en;
  logic [CH_W-1:0]                    r_rd_chan;
  logic [IDX_W-1:0]                   r_rd_index;
  logic                               r_out_valid;
  logic [NUMBER_OF_BITS-1:0]          r_out_data;
  logic                               r_busy;
  logic                               r_overrun;

  assign w_frame_accept = i_frame_strobe && (r_state == ST_IDLE);
  assign w_next_chan    = r_rd_chan + 1'b1;
  assign w_sum          = r_acc + ACC_W'(i_rd_data);

`ifdef BEAM_SAT_EN
  localparam logic signed [ACC_W-1:0] c_sat_max = ACC_W'((2 ** (NUMBER_OF_BITS - 1)) - 1);
  localparam logic signed [ACC_W-1:0] c_sat_min = ~c_sat_max;
  logic signed [ACC_W-1:0] w_shifted;
  always_comb begin
    w_shifted = w_sum >>> OUT_SHIFT;
    if (w_shifted > c_sat_max)
      w_result = c_sat_max[NUMBER_OF_BITS-1:0];
    else if (w_shifted < c_sat_min)
      w_result = c_sat_min[NUMBER_OF_BITS-1:0];
    else
      w_result = w_shifted[NUMBER_OF_BITS-1:0];
  end
`else
  always_comb w_result = NUMBER_OF_BITS'(w_sum >>> OUT_SHIFT);
`endif

  beam_delay_regfile #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .BUFFER_SIZE  (BUFFER_SIZE)
  ) u_regfile (
    .clk            (clk),
    .reset          (reset),
    .i_cfg_we       (i_cfg_we),
    .i_cfg_chan     (i_cfg_chan),
    .i_cfg_delay    (i_cfg_delay),
    .i_cfg_commit   (i_cfg_commit),
    .i_frame_accept (w_frame_accept),
    .o_active_nxt   (w_active_nxt),
    .o_cfg_err      (o_cfg_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_rd_en     <= 1'b0;
      r_rd_chan   <= '0;
      r_rd_index  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (i_frame_strobe && (r_state != ST_IDLE))
        r_overrun <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (i_frame_strobe) begin
            r_state    <= ST_ISSUE;
            r_acc      <= '0;
            r_rd_en    <= 1'b1;
            r_rd_chan  <= '0;
            r_rd_index <= w_active_nxt[0];
            r_busy     <= 1'b1;
          end
        end
        ST_ISSUE: begin
          // Read data trails the request by one cycle, so channel 0 has nothing to add yet.
          if (r_rd_chan != '0)
            r_acc <= w_sum;
          if (r_rd_chan == c_last_chan) begin
            r_state <= ST_DRAIN;
            r_rd_en <= 1'b0;
          end else begin
            r_rd_chan  <= w_next_chan;
            r_rd_index <= w_active_nxt[w_next_chan];
          end
        end
        ST_DRAIN: begin
          r_state     <= ST_OUTPUT;
          r_out_valid <= 1'b1;
          r_out_data  <= w_result;
        end
        ST_OUTPUT: begin
          if (i_out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_rd_en     = r_rd_en;
  assign o_rd_chan   = r_rd_chan;
  assign o_rd_index  = r_rd_index;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_busy      = r_busy;
  assign o_overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_beam_delay_sequencer.sv
// ============================================================================
// Module : tb_beam_delay_sequencer
// Brief  : Directed bench for two sequencer builds (N=2/shift 1, N=3/shift 0).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_beam_delay_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: 2 channels, depth 16, shift 1
  logic              a_strobe, a_we, a_commit, a_ready;
  logic [0:0]        a_chan;
  logic [3:0]        a_delay;
  logic              a_rd_en, a_valid, a_busy, a_overrun, a_cfg_err;
  logic [0:0]        a_rd_chan;
  logic [3:0]        a_rd_index;
  logic signed [7:0] a_rd_data, a_out_data;
  logic signed [7:0] a_samp [2];

  // Instance B: 3 channels, depth 12, shift 0
  logic              b_strobe, b_we, b_commit, b_ready;
  logic [1:0]        b_chan;
  logic [3:0]        b_delay;
  logic              b_rd_en, b_valid, b_busy, b_overrun, b_cfg_err;
  logic [1:0]        b_rd_chan;
  logic [3:0]        b_rd_index;
  logic signed [7:0] b_rd_data, b_out_data;
  logic signed [7:0] b_samp [3];

  int ncmp  = 0;
  int nfail = 0;

  beam_delay_sequencer #(
    .NUM_CHANNELS(2), .NUMBER_OF_BITS(8), .BUFFER_SIZE(16), .OUT_SHIFT(1)
  ) dut_a (
    .clk(clk), .reset(reset), .i_frame_strobe(a_strobe), .i_cfg_we(a_we),
    .i_cfg_chan(a_chan), .i_cfg_delay(a_delay), .i_cfg_commit(a_commit),
    .o_rd_en(a_rd_en), .o_rd_chan(a_rd_chan), .o_rd_index(a_rd_index),
    .i_rd_data(a_rd_data), .o_out_valid(a_valid), .i_out_ready(a_ready),
    .o_out_data(a_out_data), .o_busy(a_busy), .o_overrun(a_overrun),
    .o_cfg_err(a_cfg_err)
  );

  beam_delay_sequencer #(
    .NUM_CHANNELS(3), .NUMBER_OF_BITS(8), .BUFFER_SIZE(12), .OUT_SHIFT(0)
  ) dut_b (
    .clk(clk), .reset(reset), .i_frame_strobe(b_strobe), .i_cfg_we(b_we),
    .i_cfg_chan(b_chan), .i_cfg_delay(b_delay), .i_cfg_commit(b_commit),
    .o_rd_en(b_rd_en), .o_rd_chan(b_rd_chan), .o_rd_index(b_rd_index),
    .i_rd_data(b_rd_data), .o_out_valid(b_valid), .i_out_ready(b_ready),
    .o_out_data(b_out_data), .o_busy(b_busy), .o_overrun(b_overrun),
    .o_cfg_err(b_cfg_err)
  );

  // Channel buffer models: one-cycle read latency, sample chosen per channel.
  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= a_samp[a_rd_chan];
    if (b_rd_en) b_rd_data <= b_samp[b_rd_chan];
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    a_strobe = 0; a_we = 0; a_commit = 0; a_ready = 0; a_chan = 0; a_delay = 0;
    b_strobe = 0; b_we = 0; b_commit = 0; b_ready = 0; b_chan = 0; b_delay = 0;
    a_rd_data = 0; b_rd_data = 0;
    a_samp[0] = 0; a_samp[1] = 0;
    b_samp[0] = 0; b_samp[1] = 0; b_samp[2] = 0;
    step(2);
    chk("rst_rd_en", int'(a_rd_en), 0);
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_valid", int'(a_valid), 0);
    chk("rst_data", int'(a_out_data), 0);
    chk("rst_overrun", int'(a_overrun), 0);
    chk("rst_cfg_err", int'(a_cfg_err), 0);
    chk("rst_b_busy", int'(b_busy), 0);
    reset = 1'b0;
    step();

    // Basic frame, delays 0: (10+20)>>>1 = 15 at T+4
    a_samp[0] = 10; a_samp[1] = 20;
    a_strobe = 1; step(); a_strobe = 0;
    chk("t1_rd_en", int'(a_rd_en), 1);
    chk("t1_chan0", int'(a_rd_chan), 0);
    chk("t1_busy", int'(a_busy), 1);
    step();
    chk("t1_chan1", int'(a_rd_chan), 1);
    step();
    chk("t1_drain_rd_en", int'(a_rd_en), 0);
    chk("t1_early_valid", int'(a_valid), 0);
    step();
    chk("t1_valid", int'(a_valid), 1);
    chk("t1_data", int'(a_out_data), 15);
    a_ready = 1; step(); a_ready = 0;
    chk("t1_accept_valid", int'(a_valid), 0);
    chk("t1_idle_busy", int'(a_busy), 0);

    // Commit ch1=5; negative samples: (-7-4)>>>1 = -6
    a_we = 1; a_chan = 1; a_delay = 5; a_commit = 1; step();
    a_we = 0; a_commit = 0;
    chk("t2_cfg_err", int'(a_cfg_err), 0);
    a_samp[0] = -7; a_samp[1] = -4;
    a_strobe = 1; step(); a_strobe = 0;
    chk("t2_idx0", int'(a_rd_index), 0);
    step();
    chk("t2_idx1", int'(a_rd_index), 5);
    step(2);
    chk("t2_data", int'(a_out_data), -6);
    a_ready = 1; step(); a_ready = 0;
    // Uncommitted write must not reach the next frame: (-8+30)>>>1 = 11
    a_we = 1; a_chan = 1; a_delay = 9; step(); a_we = 0;
    a_samp[0] = -8; a_samp[1] = 30;
    a_strobe = 1; step(); a_strobe = 0;
    step();
    chk("t2_nocommit_idx1", int'(a_rd_index), 5);
    step(2);
    chk("t2_data2", int'(a_out_data), 11);
    a_ready = 1; step(); a_ready = 0;

    // Stalled output, second strobe dropped: (40+2)>>>1 = 21
    a_samp[0] = 40; a_samp[1] = 2;
    a_strobe = 1; step(); a_strobe = 0;
    step(3);
    chk("t3_valid", int'(a_valid), 1);
    chk("t3_data", int'(a_out_data), 21);
    chk("t3_no_overrun_yet", int'(a_overrun), 0);
    step();
    a_strobe = 1; step(); a_strobe = 0;
    chk("t3_overrun", int'(a_overrun), 1);
    chk("t3_hold_valid", int'(a_valid), 1);
    chk("t3_no_read", int'(a_rd_en), 0);
    step(3);
    chk("t3_hold_data", int'(a_out_data), 21);
    a_ready = 1; step(); a_ready = 0;
    chk("t3_accepted", int'(a_valid), 0);
    step(3);
    chk("t3_single_sample", int'(a_valid), 0);
    chk("t3_idle_busy", int'(a_busy), 0);

    // Reset mid-frame at T+2 (index 5 on the bus), then a clean frame: (3+5)>>>1 = 4
    a_samp[0] = 3; a_samp[1] = 5;
    a_strobe = 1; step(); a_strobe = 0;
    step();
    reset = 1; step();
    chk("t6_rd_en", int'(a_rd_en), 0);
    chk("t6_busy", int'(a_busy), 0);
    chk("t6_overrun", int'(a_overrun), 0);
    chk("t6_rd_index", int'(a_rd_index), 0);
    reset = 0; step();
    a_strobe = 1; step(); a_strobe = 0;
    chk("t6_idx0", int'(a_rd_index), 0);
    step();
    chk("t6_idx1", int'(a_rd_index), 0);
    step(2);
    chk("t6_data", int'(a_out_data), 4);
    a_ready = 1; step(); a_ready = 0;

    // Instance B, output reduction: 127+127+0 = 254 with no shift
    b_samp[0] = 127; b_samp[1] = 127; b_samp[2] = 0;
    b_strobe = 1; step(); b_strobe = 0;
    step(3);
    chk("t4_early_valid", int'(b_valid), 0);
    step();
    chk("t4_valid", int'(b_valid), 1);
`ifdef BEAM_SAT_EN
    chk("t4_pos", int'(b_out_data), 127);
`else
    chk("t4_pos", int'(b_out_data), -2);
`endif
    b_ready = 1; step(); b_ready = 0;
    // -128-128-1 = -257
    b_samp[0] = -128; b_samp[1] = -128; b_samp[2] = -1;
    b_strobe = 1; step(); b_strobe = 0;
    step(4);
`ifdef BEAM_SAT_EN
    chk("t4_neg", int'(b_out_data), -128);
`else
    chk("t4_neg", int'(b_out_data), -1);
`endif
    b_ready = 1; step(); b_ready = 0;

    // Clamp delay 15 (depth 12) to 11; out-of-range channel 3 ignored
    b_we = 1; b_chan = 2; b_delay = 15; b_commit = 1; step();
    b_we = 0; b_commit = 0;
    chk("t5_clamp_err", int'(b_cfg_err), 1);
    step();
    chk("t5_err_pulse", int'(b_cfg_err), 0);
    b_we = 1; b_chan = 3; b_delay = 7; step(); b_we = 0;
    chk("t5_chan_err", int'(b_cfg_err), 1);
    b_samp[0] = 1; b_samp[1] = 2; b_samp[2] = 3;
    b_strobe = 1; step(); b_strobe = 0;
    chk("t5_idx0", int'(b_rd_index), 0);
    step();
    chk("t5_idx1", int'(b_rd_index), 0);
    step();
    chk("t5_idx2", int'(b_rd_index), 11);
    step(2);
    chk("t5_data", int'(b_out_data), 6);
    b_ready = 1; step(); b_ready = 0;
    chk("t5_b_overrun", int'(b_overrun), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

`default_nettype wire
